// File: rtl/neuron_mac_pu_pkg.sv
// Shared definitions for the neuron processing unit: FSM state encoding and
// the width helpers used to size the accumulator.
package neuron_mac_pu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      BIAS = 2'd2,
      DONE = 2'd3
   } pu_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Wide enough that N_IN full-precision products plus the shifted bias never overflow.
   function automatic int acc_width(input int width, input int n_in);
      return 2 * width + clog2(n_in) + 1;
   endfunction

endpackage

// File: rtl/neuron_mac_pu_lane.sv
// One MAC beat: LANES signed full-precision multipliers feeding an adder tree,
// purely combinational, result sign-extended to the accumulator width.
module neuron_mac_pu_lane #(
   parameter int WIDTH = 16,
   parameter int LANES = 2,
   parameter int ACC_W = 36
) (
   input  logic        [LANES*WIDTH-1:0] x_beat,
   input  logic        [LANES*WIDTH-1:0] w_beat,
   output logic signed [ACC_W-1:0]       beat_sum
);

   logic signed [2*WIDTH-1:0] prod;

   always_comb begin
      prod     = '0;
      beat_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         prod     = $signed(x_beat[i*WIDTH +: WIDTH]) * $signed(w_beat[i*WIDTH +: WIDTH]);
         beat_sum = beat_sum + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
      end
   end

endmodule

// File: rtl/neuron_mac_pu.sv
// Sequential neuron: dot product over N_IN/LANES beats, bias add, floor shift,
// saturation. Optional ReLU on the output when PU_RELU_EN is defined.
module neuron_mac_pu
   import neuron_mac_pu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8,
   parameter int N_IN  = 8,
   parameter int LANES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N_IN*WIDTH-1:0] x_flat,
   input  logic [N_IN*WIDTH-1:0] w_flat,
   input  logic [WIDTH-1:0]      bias,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out,
   output logic                  sat
);

   localparam int BEATS     = N_IN / LANES;
   localparam int ACC_W     = acc_width(WIDTH, N_IN);
   localparam int CNT_W     = (BEATS > 1) ? clog2(BEATS) : 1;
   localparam int BEAT_BITS = LANES * WIDTH;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   if (N_IN % LANES != 0) begin : g_lane_check
      $error("neuron_mac_pu: N_IN must be a multiple of LANES");
   end

   pu_state_t               state;
   logic [CNT_W-1:0]        beat;
   logic [N_IN*WIDTH-1:0]   x_reg;
   logic [N_IN*WIDTH-1:0]   w_reg;
   logic [WIDTH-1:0]        bias_reg;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] beat_sum;
   logic signed [ACC_W-1:0] bias_ext;
   logic signed [ACC_W-1:0] total;
   logic signed [ACC_W-1:0] shifted;
   logic [WIDTH-1:0]        res_next;
   logic                    sat_next;
   logic [BEAT_BITS-1:0]    x_beat;
   logic [BEAT_BITS-1:0]    w_beat;

   assign x_beat = x_reg[int'(beat)*BEAT_BITS +: BEAT_BITS];
   assign w_beat = w_reg[int'(beat)*BEAT_BITS +: BEAT_BITS];

   neuron_mac_pu_lane #(
      .WIDTH(WIDTH),
      .LANES(LANES),
      .ACC_W(ACC_W)
   ) u_lane (
      .x_beat  (x_beat),
      .w_beat  (w_beat),
      .beat_sum(beat_sum)
   );

   // Bias is aligned to the product scale (2*FRAC) before the floor shift back to FRAC.
   always_comb begin
      bias_ext = {{(ACC_W-WIDTH){bias_reg[WIDTH-1]}}, bias_reg};
      total    = acc + (bias_ext <<< FRAC);
      shifted  = total >>> FRAC;
      sat_next = 1'b0;
      res_next = shifted[WIDTH-1:0];
      if (shifted > SAT_MAX) begin
         res_next = SAT_MAX[WIDTH-1:0];
         sat_next = 1'b1;
      end else if (shifted < SAT_MIN) begin
         res_next = SAT_MIN[WIDTH-1:0];
         sat_next = 1'b1;
      end
`ifdef PU_RELU_EN
      if (res_next[WIDTH-1]) res_next = '0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         beat      <= '0;
         x_reg     <= '0;
         w_reg     <= '0;
         bias_reg  <= '0;
         acc       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out       <= '0;
         sat       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_reg    <= x_flat;
                  w_reg    <= w_flat;
                  bias_reg <= bias;
                  acc      <= '0;
                  beat     <= '0;
                  in_ready <= 1'b0;
                  state    <= MAC;
               end
            end
            MAC: begin
               acc <= acc + beat_sum;
               if (beat == LAST_BEAT) begin
                  beat  <= '0;
                  state <= BIAS;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
            BIAS: begin
               out       <= res_next;
               sat       <= sat_next;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_pu.sv
// Scoreboard bench for neuron_mac_pu: directed vectors push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_neuron_mac_pu;

   localparam int W = 16;
   localparam int N = 8;

   typedef struct {
      logic [W-1:0] out;
      logic         sat;
   } exp_t;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] x_flat;
   logic [N*W-1:0] w_flat;
   logic [W-1:0]   bias;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out;
   logic           sat;

   exp_t sb[$];
   int   checks;
   int   errors;

   neuron_mac_pu #(
      .WIDTH(16),
      .FRAC (8),
      .N_IN (8),
      .LANES(2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x_flat   (x_flat),
      .w_flat   (w_flat),
      .bias     (bias),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out      (out),
      .sat      (sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
      logic [N*W-1:0] f;
      for (int i = 0; i < N; i++) f[i*W +: W] = v;
      return f;
   endfunction

   // Drives one operand set once the DUT is ready; returns just after the accepting edge.
   task automatic applyStimulus(input logic [N*W-1:0] xv, input logic [N*W-1:0] wv,
                                input logic [W-1:0] bv, input logic [W-1:0] eo,
                                input logic es, input bit push);
      exp_t e;
      int   n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL in_ready_timeout: got 0, expected 1");
      end
      x_flat   = xv;
      w_flat   = wv;
      bias     = bv;
      in_valid = 1'b1;
      if (push) begin
         e.out = eo;
         e.sat = es;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got out=0x%04h with empty scoreboard, expected none", out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("result_out", out, e.out);
            checkOutput("result_sat", {15'b0, sat}, {15'b0, e.sat});
         end
      end
   end

   initial begin
      logic [N*W-1:0] xv;
      logic [N*W-1:0] wv;
      logic [W-1:0]   hold_out;
      logic           hold_sat;
      logic [W-1:0]   neg_exp;
      logic [W-1:0]   relu_exp;
      int             n;
      int             spurious;

      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x_flat    = '0;
      w_flat    = '0;
      bias      = '0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_in_ready",  {15'b0, in_ready},  16'd1);
      checkOutput("reset_out_valid", {15'b0, out_valid}, 16'd0);
      checkOutput("reset_out",       out,                16'h0000);
      checkOutput("reset_sat",       {15'b0, sat},       16'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1.0 * 1.0 summed eight times, with accept-to-valid latency
      applyStimulus(fill(16'h0100), fill(16'h0100), 16'h0000, 16'h0800, 1'b0, 1'b1);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("latency_cycles", 16'(n), 16'd5);
      checkOutput("busy_in_ready", {15'b0, in_ready}, 16'd0);

      applyStimulus(fill(16'h7FFF), fill(16'h7FFF), 16'h7FFF, 16'h7FFF, 1'b1, 1'b1);

`ifdef PU_RELU_EN
      relu_exp = 16'h0000;
`else
      relu_exp = 16'hF880;
`endif
      applyStimulus(fill(16'h0100), fill(16'hFF00), 16'h0080, relu_exp, 1'b0, 1'b1);

      for (int i = 0; i < N; i++) xv[i*W +: W] = 16'(i * 256);
      applyStimulus(xv, fill(16'h0080), 16'hFF00, 16'h0D00, 1'b0, 1'b1);

      // Distinct x and w per input exercise beat/lane indexing: sum (i+1)^2*4096 >> 8
      for (int i = 0; i < N; i++) begin
         xv[i*W +: W] = 16'((i + 1) * 256);
         wv[i*W +: W] = 16'((i + 1) * 16);
      end
      applyStimulus(xv, wv, 16'h0000, 16'h0CC0, 1'b0, 1'b1);

`ifdef PU_RELU_EN
      neg_exp = 16'h0000;
`else
      neg_exp = 16'h8000;
`endif
      applyStimulus(fill(16'h7FFF), fill(16'h8000), 16'h0000, neg_exp, 1'b1, 1'b1);
      applyStimulus('0, '0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1);

      // Floor shift: tiny positive product truncates to 0, tiny negative to -1
      xv = '0;
      wv = '0;
      xv[W-1:0] = 16'h0001;
      wv[W-1:0] = 16'h0001;
      applyStimulus(xv, wv, 16'h0000, 16'h0000, 1'b0, 1'b1);
      wv[W-1:0] = 16'hFFFF;
`ifdef PU_RELU_EN
      applyStimulus(xv, wv, 16'h0000, 16'h0000, 1'b0, 1'b1);
`else
      applyStimulus(xv, wv, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
`endif

      // Downstream stall: result held, new operands ignored
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) xv[i*W +: W] = 16'(i * 256);
      applyStimulus(xv, fill(16'h0080), 16'hFF00, 16'h0D00, 1'b0, 1'b1);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      hold_out = out;
      hold_sat = sat;
      checkOutput("stall_first_out", hold_out, 16'h0D00);
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0];
         x_flat   = fill(16'h1234);
         w_flat   = fill(16'h4321);
         @(posedge clk);
         #1;
         checkOutput("stall_out_valid", {15'b0, out_valid}, 16'd1);
         checkOutput("stall_in_ready",  {15'b0, in_ready},  16'd0);
         checkOutput("stall_out",       out,                hold_out);
         checkOutput("stall_sat",       {15'b0, sat},       {15'b0, hold_sat});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Reset at beat 2 of MAC must abort without emitting anything
      applyStimulus(fill(16'h7FFF), fill(16'h7FFF), 16'h0000, 16'h0000, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_out_valid", {15'b0, out_valid}, 16'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("abort_in_ready", {15'b0, in_ready}, 16'd1);
      spurious = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) spurious++;
      end
      checkOutput("abort_no_output", 16'(spurious), 16'd0);
      applyStimulus(fill(16'h0100), fill(16'h0100), 16'h0000, 16'h0800, 1'b0, 1'b1);

      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("scoreboard_drained", 16'(sb.size()), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
